wb_unit: RTL and testbench
==========================

Name: wb_unit

Overview:
- Parametrised write-back stage for the pak-rv pipeline, sitting between the memory stage and the register file.
- Selects the write-back source: ALU result, load data, PC+4 or CSR read data.
- Aligns and sign-/zero-extends load data and stalls on variable-latency data-memory responses.
- Supports flush of a pending load and keeps a 64-bit retired-instruction counter.
- All register-file write outputs are registered.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- OFF_W, $clog2(XLEN/8), width of the load byte offset (derived; not overridden).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset; synchronous, active-high.
- in_valid  input  1  memory stage presents an instruction.
- in_ready  output  1  unit can accept an instruction this cycle.
- in_wb_sel  input  2  source select: 0 ALU, 1 load, 2 PC+4, 3 CSR.
- in_wb_en  input  1  instruction writes rd.
- in_rd  input  5  destination register.
- in_opr_res  input  XLEN  ALU result.
- in_pc4  input  XLEN  PC+4.
- in_csr_rdata  input  XLEN  CSR read value.
- in_ld_funct3  input  3  load funct3.
- in_ld_offset  input  OFF_W  load address low bits.
- flush  input  1  kill any pending load.
- dmem_rvalid  input  1  data-memory response valid.
- dmem_rdata  input  XLEN  raw data-memory word.
- dmem_rerr  input  1  bus error, qualified by dmem_rvalid.
- wb_en  output  1  register-file write enable.
- wb_rd  output  5  register-file write address.
- wb_data  output  XLEN  register-file write data.
- retire_valid  output  1  one instruction retired this cycle.
- ld_fault  output  1  load faulted this cycle.
- instret  output  64  retired-instruction count.

Behaviour:
- Reset values:
  - State IDLE; drop_pending 0.
  - wb_en, retire_valid, ld_fault 0; wb_rd 0; wb_data 0; instret 0.
  - in_ready is 0 during the reset cycle.
- in_ready = (state==IDLE) && !rst. Accept = in_valid && in_ready.
- Non-load accept (wb_sel != 1):
  - Next cycle: wb_en = in_wb_en && (in_rd != 0), wb_rd = in_rd, retire_valid = 1.
  - wb_data: sel 0 -> in_opr_res, sel 2 -> in_pc4, sel 3 -> in_csr_rdata.
- Output pulses: wb_en, retire_valid and ld_fault are single-cycle pulses, 0 when nothing completes. wb_rd and wb_data hold their last value.
- Load accept, dmem_rvalid high in the same cycle: completes next cycle, as for non-load (1-cycle latency).
- Load accept, dmem_rvalid low:
  - Latch rd, wb_en, funct3 and offset; go to WAIT_LOAD; in_ready drops.
  - On dmem_rvalid: complete next cycle and return to IDLE.
  - in_ready is high in the completion cycle.
- Load formatting; byte lane = offset*8:
  - funct3 0 LB: sign-extend byte.
  - funct3 4 LBU: zero-extend byte.
  - funct3 1 LH / 5 LHU: halfword; offset[0] must be 0.
  - funct3 2 LW: word. funct3 6 LWU (XLEN=64 only): word, zero-extended. Word offset must be multiple of 4.
  - funct3 3 LD (XLEN=64 only): offset must be 0.
  - Misaligned offset, undefined funct3, or dmem_rerr -> fault.
- Fault: ld_fault=1, wb_en=0, retire_valid=0 next cycle. instret not incremented.
- Flush:
  - Flush in WAIT_LOAD with no dmem_rvalid that cycle: return to IDLE, set drop_pending. No write, no retire.
  - While drop_pending, the next dmem_rvalid is swallowed and clears drop_pending. It is not a fault.
  - Flush in WAIT_LOAD with dmem_rvalid in the same cycle: response is discarded, drop_pending not set.
  - Flush in IDLE blocks the accept in that cycle.
- drop_pending and acceptance:
  - While drop_pending, a load accepted in IDLE never completes from a same-cycle response; that response is the swallowed one. The load goes to WAIT_LOAD.
  - Non-loads are unaffected by drop_pending.
- Stray response: dmem_rvalid in IDLE with no drop_pending and no load accept is ignored.
- instret increments by 1 in the cycle retire_valid is high and wraps at 2^64-1 -> 0.
- rst mid-WAIT_LOAD: state IDLE, drop_pending 0, all outputs to reset values. The memory side is reset together with this unit, so no outstanding response survives reset.

Test Plan:
- Back-to-back non-load traffic: ALU rd=5 0x1234, PC+4 rd=1 0x80000004, CSR rd=0 0xAB.
  - Expect writes on consecutive cycles.
  - Third has wb_en=0 but retire_valid=1; instret=3.
- Load with immediate response: LB, offset 3, rdata 0x80FF_0000. Expect wb_data 0xFFFFFF80 one cycle later; LBU gives 0x00000080.
- Load with 4-cycle latency: LH, offset 2, rdata 0x8001_xxxx, then ALU op on in_valid.
  - in_ready low 4 cycles; wb_data 0xFFFF8001.
  - ALU result written the cycle after.
- Faults: LW offset 1 -> ld_fault=1, no wb_en. LH with dmem_rerr=1 -> same. instret unchanged.
- Flush while waiting, then late response and a new load accept: late response swallowed; new load waits for its own response and writes the correct value.
- XLEN=64: LD offset 0 -> full word. LWU rdata 0x...._8000_0000 -> 0x0000_0000_8000_0000. Reset asserted in WAIT_LOAD -> all outputs 0, in_ready high the cycle after reset deasserts.

Source files
------------

// File: rtl/wb_unit.sv
// Write-back stage for the pak-rv pipeline: picks the rd source, formats load data,
// waits on variable-latency data-memory responses and counts retired instructions.
module wb_unit #(
  parameter int unsigned XLEN = 32,
  localparam int unsigned OFF_W = $clog2(XLEN / 8)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_wb_sel,
  input  logic             in_wb_en,
  input  logic [4:0]       in_rd,
  input  logic [XLEN-1:0]  in_opr_res,
  input  logic [XLEN-1:0]  in_pc4,
  input  logic [XLEN-1:0]  in_csr_rdata,
  input  logic [2:0]       in_ld_funct3,
  input  logic [OFF_W-1:0] in_ld_offset,
  input  logic             flush,
  input  logic             dmem_rvalid,
  input  logic [XLEN-1:0]  dmem_rdata,
  input  logic             dmem_rerr,
  output logic             wb_en,
  output logic [4:0]       wb_rd,
  output logic [XLEN-1:0]  wb_data,
  output logic             retire_valid,
  output logic             ld_fault,
  output logic [63:0]      instret
);

  localparam int unsigned SH_W = OFF_W + 3;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_drop;
  logic              w_drop_nxt;

  logic              r_ld_en;
  logic [4:0]        r_ld_rd;
  logic [2:0]        r_ld_f3;
  logic [OFF_W-1:0]  r_ld_off;

  logic              r_wb_en;
  logic [4:0]        r_wb_rd;
  logic [XLEN-1:0]   r_wb_data;
  logic              r_retire;
  logic              r_fault;
  logic [63:0]       r_instret;

  logic              w_accept;
  logic              w_is_load;
  logic              w_rsp_live;
  logic              w_ld_done;
  logic              w_sel_en;
  logic [4:0]        w_sel_rd;
  logic [2:0]        w_sel_f3;
  logic [OFF_W-1:0]  w_sel_off;
  logic [SH_W-1:0]   w_shamt;
  logic [XLEN-1:0]   w_shift;
  logic [XLEN-1:0]   w_ld_data;
  logic              w_ld_bad;

  logic              w_en_nxt;
  logic [4:0]        w_rd_nxt;
  logic [XLEN-1:0]   w_data_nxt;
  logic              w_retire_nxt;
  logic              w_fault_nxt;

  assign in_ready   = (r_state == S_IDLE) && !rst;
  // Flush in IDLE suppresses the accept even though in_ready stays high.
  assign w_accept   = in_valid && in_ready && !flush;
  assign w_is_load  = (in_wb_sel == 2'd1);
  // A response arriving while a drop is pending belongs to a killed load.
  assign w_rsp_live = dmem_rvalid && !r_drop;

  // Loads format with same-cycle instruction fields in IDLE, latched ones in WAIT.
  assign w_sel_en  = (r_state == S_IDLE) ? in_wb_en     : r_ld_en;
  assign w_sel_rd  = (r_state == S_IDLE) ? in_rd        : r_ld_rd;
  assign w_sel_f3  = (r_state == S_IDLE) ? in_ld_funct3 : r_ld_f3;
  assign w_sel_off = (r_state == S_IDLE) ? in_ld_offset : r_ld_off;
  assign w_shamt   = {w_sel_off, 3'b000};
  assign w_shift   = dmem_rdata >> w_shamt;

  assign w_ld_done = ((r_state == S_IDLE) && w_accept && w_is_load && w_rsp_live) ||
                     ((r_state == S_WAIT) && !flush && w_rsp_live);

  // Load alignment and extension
  always_comb begin
    w_ld_data = '0;
    w_ld_bad  = 1'b0;
    case (w_sel_f3)
      3'd0: w_ld_data = XLEN'($signed(w_shift[7:0]));
      3'd4: w_ld_data = XLEN'(w_shift[7:0]);
      3'd1: begin
        w_ld_data = XLEN'($signed(w_shift[15:0]));
        w_ld_bad  = w_sel_off[0];
      end
      3'd5: begin
        w_ld_data = XLEN'(w_shift[15:0]);
        w_ld_bad  = w_sel_off[0];
      end
      3'd2: begin
        w_ld_data = XLEN'($signed(w_shift[31:0]));
        w_ld_bad  = (w_sel_off[1:0] != 2'd0);
      end
      3'd6: begin
        w_ld_data = XLEN'(w_shift[31:0]);
        w_ld_bad  = (XLEN != 64) || (w_sel_off[1:0] != 2'd0);
      end
      3'd3: begin
        w_ld_data = w_shift;
        w_ld_bad  = (XLEN != 64) || (w_sel_off != '0);
      end
      default: w_ld_bad = 1'b1;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_drop  <= w_drop_nxt;
    end
  end

  // Next state
  always_comb begin
    w_state_nxt = r_state;
    w_drop_nxt  = r_drop;
    if (r_drop && dmem_rvalid) w_drop_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept && w_is_load && !w_rsp_live) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (flush) begin
          w_state_nxt = S_IDLE;
          if (!w_rsp_live) w_drop_nxt = 1'b1;
        end else if (w_rsp_live) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered write-back outputs
  always_comb begin
    w_en_nxt     = 1'b0;
    w_rd_nxt     = r_wb_rd;
    w_data_nxt   = r_wb_data;
    w_retire_nxt = 1'b0;
    w_fault_nxt  = 1'b0;
    if ((r_state == S_IDLE) && w_accept && !w_is_load) begin
      w_retire_nxt = 1'b1;
      w_en_nxt     = in_wb_en && (in_rd != 5'd0);
      w_rd_nxt     = in_rd;
      case (in_wb_sel)
        2'd2:    w_data_nxt = in_pc4;
        2'd3:    w_data_nxt = in_csr_rdata;
        default: w_data_nxt = in_opr_res;
      endcase
    end else if (w_ld_done) begin
      if (w_ld_bad || dmem_rerr) begin
        w_fault_nxt = 1'b1;
      end else begin
        w_retire_nxt = 1'b1;
        w_en_nxt     = w_sel_en && (w_sel_rd != 5'd0);
        w_rd_nxt     = w_sel_rd;
        w_data_nxt   = w_ld_data;
      end
    end
  end

  // Pending-load context
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ld_en  <= 1'b0;
      r_ld_rd  <= 5'd0;
      r_ld_f3  <= 3'd0;
      r_ld_off <= '0;
    end else if (w_accept) begin
      r_ld_en  <= in_wb_en;
      r_ld_rd  <= in_rd;
      r_ld_f3  <= in_ld_funct3;
      r_ld_off <= in_ld_offset;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wb_en   <= 1'b0;
      r_wb_rd   <= 5'd0;
      r_wb_data <= '0;
      r_retire  <= 1'b0;
      r_fault   <= 1'b0;
      r_instret <= 64'd0;
    end else begin
      r_wb_en   <= w_en_nxt;
      r_wb_rd   <= w_rd_nxt;
      r_wb_data <= w_data_nxt;
      r_retire  <= w_retire_nxt;
      r_fault   <= w_fault_nxt;
      if (w_retire_nxt) r_instret <= r_instret + 64'd1;
    end
  end

  assign wb_en        = r_wb_en;
  assign wb_rd        = r_wb_rd;
  assign wb_data      = r_wb_data;
  assign retire_valid = r_retire;
  assign ld_fault     = r_fault;
  assign instret      = r_instret;

endmodule

// File: tb/tb_wb_unit.sv
// Scoreboard bench for wb_unit: a 32-bit and a 64-bit instance share the narrow
// instruction fields; expected completions are queued per instance and popped on output.
module tb_wb_unit;

  typedef struct {
    logic        fault;
    logic        en;
    logic [4:0]  rd;
    logic [63:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst32, rst64;
  logic        in_valid32, in_valid64;
  logic [1:0]  in_wb_sel;
  logic        in_wb_en;
  logic [4:0]  in_rd;
  logic [63:0] in_opr_res, in_pc4, in_csr_rdata, dmem_rdata;
  logic [2:0]  in_ld_funct3;
  logic [2:0]  in_ld_offset;
  logic        flush, dmem_rerr;
  logic        rvalid32, rvalid64;

  logic        in_ready32, wb_en32, retire32, fault32;
  logic [4:0]  wb_rd32;
  logic [31:0] wb_data32;
  logic [63:0] instret32;
  logic        in_ready64, wb_en64, retire64, fault64;
  logic [4:0]  wb_rd64;
  logic [63:0] wb_data64;
  logic [63:0] instret64;

  int   n_chk = 0;
  int   n_err = 0;
  int   exp_ret32 = 0;
  int   exp_ret64 = 0;
  exp_t q32[$];
  exp_t q64[$];

  always #5 clk = ~clk;

  wb_unit #(.XLEN(32)) dut32 (
    .clk(clk), .rst(rst32), .in_valid(in_valid32), .in_ready(in_ready32),
    .in_wb_sel(in_wb_sel), .in_wb_en(in_wb_en), .in_rd(in_rd),
    .in_opr_res(in_opr_res[31:0]), .in_pc4(in_pc4[31:0]), .in_csr_rdata(in_csr_rdata[31:0]),
    .in_ld_funct3(in_ld_funct3), .in_ld_offset(in_ld_offset[1:0]), .flush(flush),
    .dmem_rvalid(rvalid32), .dmem_rdata(dmem_rdata[31:0]), .dmem_rerr(dmem_rerr),
    .wb_en(wb_en32), .wb_rd(wb_rd32), .wb_data(wb_data32),
    .retire_valid(retire32), .ld_fault(fault32), .instret(instret32)
  );

  wb_unit #(.XLEN(64)) dut64 (
    .clk(clk), .rst(rst64), .in_valid(in_valid64), .in_ready(in_ready64),
    .in_wb_sel(in_wb_sel), .in_wb_en(in_wb_en), .in_rd(in_rd),
    .in_opr_res(in_opr_res), .in_pc4(in_pc4), .in_csr_rdata(in_csr_rdata),
    .in_ld_funct3(in_ld_funct3), .in_ld_offset(in_ld_offset), .flush(flush),
    .dmem_rvalid(rvalid64), .dmem_rdata(dmem_rdata), .dmem_rerr(dmem_rerr),
    .wb_en(wb_en64), .wb_rd(wb_rd64), .wb_data(wb_data64),
    .retire_valid(retire64), .ld_fault(fault64), .instret(instret64)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push32(input logic f, input logic en, input logic [4:0] rd, input logic [63:0] d);
    exp_t e;
    e.fault = f; e.en = en; e.rd = rd; e.data = d;
    q32.push_back(e);
    if (!f) exp_ret32++;
  endtask

  task automatic push64(input logic f, input logic en, input logic [4:0] rd, input logic [63:0] d);
    exp_t e;
    e.fault = f; e.en = en; e.rd = rd; e.data = d;
    q64.push_back(e);
    if (!f) exp_ret64++;
  endtask

  task automatic drive_load(input logic [4:0] rd, input logic [2:0] f3, input logic [2:0] off);
    in_wb_sel = 2'd1; in_wb_en = 1'b1; in_rd = rd; in_ld_funct3 = f3; in_ld_offset = off;
  endtask

  // 32-bit completion monitor
  always @(negedge clk) begin
    if (!rst32 && (retire32 || fault32)) begin
      if (q32.size() == 0) begin
        chk("unexpected_out32", 64'(1), 64'(0));
      end else begin
        exp_t e;
        e = q32.pop_front();
        chk("ld_fault32", 64'(fault32), 64'(e.fault));
        chk("retire32", 64'(retire32), 64'(!e.fault));
        chk("wb_en32", 64'(wb_en32), 64'(e.en));
        if (!e.fault) begin
          chk("wb_rd32", 64'(wb_rd32), 64'(e.rd));
          chk("wb_data32", 64'(wb_data32), e.data);
        end
      end
    end
  end

  // 64-bit completion monitor
  always @(negedge clk) begin
    if (!rst64 && (retire64 || fault64)) begin
      if (q64.size() == 0) begin
        chk("unexpected_out64", 64'(1), 64'(0));
      end else begin
        exp_t e;
        e = q64.pop_front();
        chk("ld_fault64", 64'(fault64), 64'(e.fault));
        chk("retire64", 64'(retire64), 64'(!e.fault));
        chk("wb_en64", 64'(wb_en64), 64'(e.en));
        if (!e.fault) begin
          chk("wb_rd64", 64'(wb_rd64), 64'(e.rd));
          chk("wb_data64", wb_data64, e.data);
        end
      end
    end
  end

  initial begin
    rst32 = 1'b1; rst64 = 1'b1;
    in_valid32 = 1'b0; in_valid64 = 1'b0;
    in_wb_sel = 2'd0; in_wb_en = 1'b0; in_rd = 5'd0;
    in_opr_res = '0; in_pc4 = '0; in_csr_rdata = '0; dmem_rdata = '0;
    in_ld_funct3 = 3'd0; in_ld_offset = 3'd0;
    flush = 1'b0; dmem_rerr = 1'b0; rvalid32 = 1'b0; rvalid64 = 1'b0;

    // Reset
    step(); step();
    chk("rst_in_ready", 64'(in_ready32), 64'(0));
    chk("rst_wb_en", 64'(wb_en32), 64'(0));
    chk("rst_wb_rd", 64'(wb_rd32), 64'(0));
    chk("rst_wb_data", 64'(wb_data32), 64'(0));
    chk("rst_instret", instret32, 64'(0));
    chk("rst_retire", 64'(retire32), 64'(0));
    rst32 = 1'b0; rst64 = 1'b0;
    #1;
    chk("ready_after_rst", 64'(in_ready32), 64'(1));
    step();

    // Back-to-back non-loads
    in_valid32 = 1'b1; in_wb_en = 1'b1;
    in_wb_sel = 2'd0; in_rd = 5'd5; in_opr_res = 64'h1234;
    push32(1'b0, 1'b1, 5'd5, 64'h1234);
    step();
    chk("b2b_ready", 64'(in_ready32), 64'(1));
    in_wb_sel = 2'd2; in_rd = 5'd1; in_pc4 = 64'h8000_0004;
    push32(1'b0, 1'b1, 5'd1, 64'h8000_0004);
    step();
    in_wb_sel = 2'd3; in_rd = 5'd0; in_csr_rdata = 64'hAB;
    push32(1'b0, 1'b0, 5'd0, 64'hAB);
    step();
    in_valid32 = 1'b0;
    step(); step();
    chk("instret_b2b", instret32, 64'(3));

    // Loads with a same-cycle response
    in_valid32 = 1'b1; rvalid32 = 1'b1; dmem_rdata = 64'h80FF_0000;
    drive_load(5'd7, 3'd0, 3'd3);
    push32(1'b0, 1'b1, 5'd7, 64'hFFFF_FF80);
    step();
    drive_load(5'd7, 3'd4, 3'd3);
    push32(1'b0, 1'b1, 5'd7, 64'h0000_0080);
    step();
    in_valid32 = 1'b0; rvalid32 = 1'b0;
    step();

    // LH with 4-cycle response latency, ALU op queued behind it
    in_valid32 = 1'b1;
    drive_load(5'd12, 3'd1, 3'd2);
    chk("lh_accept_ready", 64'(in_ready32), 64'(1));
    step();
    in_wb_sel = 2'd0; in_rd = 5'd9; in_opr_res = 64'h55;
    for (int i = 0; i < 3; i++) begin
      chk("lh_wait_ready", 64'(in_ready32), 64'(0));
      step();
    end
    rvalid32 = 1'b1; dmem_rdata = 64'h8001_1234;
    chk("lh_rsp_ready", 64'(in_ready32), 64'(0));
    push32(1'b0, 1'b1, 5'd12, 64'hFFFF_8001);
    step();
    rvalid32 = 1'b0;
    chk("lh_done_ready", 64'(in_ready32), 64'(1));
    push32(1'b0, 1'b1, 5'd9, 64'h55);
    step();
    in_valid32 = 1'b0;
    step();

    // Faults: misaligned LW, bus error on LH
    in_valid32 = 1'b1; rvalid32 = 1'b1; dmem_rdata = 64'h1111_2222;
    drive_load(5'd3, 3'd2, 3'd1);
    push32(1'b1, 1'b0, 5'd3, 64'h0);
    step();
    drive_load(5'd4, 3'd1, 3'd0); dmem_rerr = 1'b1;
    push32(1'b1, 1'b0, 5'd4, 64'h0);
    step();
    in_valid32 = 1'b0; rvalid32 = 1'b0; dmem_rerr = 1'b0;
    step(); step();
    chk("instret_fault", instret32, 64'(exp_ret32));

    // Flush while waiting, late response swallowed by a new load
    in_valid32 = 1'b1;
    drive_load(5'd10, 3'd2, 3'd0);
    step();
    in_valid32 = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_idle_ready", 64'(in_ready32), 64'(1));
    in_valid32 = 1'b1; drive_load(5'd11, 3'd2, 3'd0);
    rvalid32 = 1'b1; dmem_rdata = 64'hDEAD_BEEF;
    step();
    in_valid32 = 1'b0; rvalid32 = 1'b0;
    chk("swallow_wait_ready", 64'(in_ready32), 64'(0));
    step();
    chk("swallow_wait_ready2", 64'(in_ready32), 64'(0));
    rvalid32 = 1'b1; dmem_rdata = 64'hCAFE_0001;
    push32(1'b0, 1'b1, 5'd11, 64'hCAFE_0001);
    step();
    rvalid32 = 1'b0;

    // Flush coinciding with the response: discarded, no drop left behind
    in_valid32 = 1'b1; drive_load(5'd13, 3'd2, 3'd0);
    step();
    in_valid32 = 1'b0; flush = 1'b1; rvalid32 = 1'b1; dmem_rdata = 64'h1;
    step();
    flush = 1'b0;
    chk("flush_rsp_ready", 64'(in_ready32), 64'(1));
    // Stray response in IDLE is ignored
    step();
    rvalid32 = 1'b0;

    // Flush in IDLE blocks the accept; the held instruction goes the cycle after
    in_valid32 = 1'b1; in_wb_sel = 2'd0; in_wb_en = 1'b1; in_rd = 5'd14; in_opr_res = 64'h77;
    flush = 1'b1;
    step();
    flush = 1'b0;
    push32(1'b0, 1'b1, 5'd14, 64'h77);
    step();
    drive_load(5'd15, 3'd4, 3'd1); rvalid32 = 1'b1; dmem_rdata = 64'h0000_AB00;
    push32(1'b0, 1'b1, 5'd15, 64'hAB);
    step();
    in_valid32 = 1'b0; rvalid32 = 1'b0;
    step(); step();
    chk("instret_final32", instret32, 64'(exp_ret32));

    // XLEN=64: LD and LWU
    in_valid64 = 1'b1; rvalid64 = 1'b1;
    drive_load(5'd3, 3'd3, 3'd0); dmem_rdata = 64'h1122_3344_5566_7788;
    push64(1'b0, 1'b1, 5'd3, 64'h1122_3344_5566_7788);
    step();
    drive_load(5'd4, 3'd6, 3'd0); dmem_rdata = 64'h1234_5678_8000_0000;
    push64(1'b0, 1'b1, 5'd4, 64'h0000_0000_8000_0000);
    step();
    in_valid64 = 1'b0; rvalid64 = 1'b0;
    step();
    chk("instret64", instret64, 64'(exp_ret64));

    // XLEN=64: reset while a load is outstanding
    in_valid64 = 1'b1; drive_load(5'd5, 3'd2, 3'd0);
    step();
    in_valid64 = 1'b0;
    chk("wait64_ready", 64'(in_ready64), 64'(0));
    step();
    rst64 = 1'b1;
    step();
    chk("rst64_ready", 64'(in_ready64), 64'(0));
    chk("rst64_wb_en", 64'(wb_en64), 64'(0));
    chk("rst64_wb_rd", 64'(wb_rd64), 64'(0));
    chk("rst64_wb_data", wb_data64, 64'(0));
    chk("rst64_instret", instret64, 64'(0));
    chk("rst64_retire", 64'(retire64), 64'(0));
    chk("rst64_fault", 64'(fault64), 64'(0));
    rst64 = 1'b0;
    #1;
    chk("rst64_release_ready", 64'(in_ready64), 64'(1));
    step(); step();

    chk("q32_drained", 64'(q32.size()), 64'(0));
    chk("q64_drained", 64'(q64.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
